// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int          IN_W_DEF     = 14;
  localparam int          NDIG_DEF     = 4;
  localparam int unsigned MAX_VAL      = 9999;
  localparam logic [3:0]  BLANK_NIBBLE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a binary producer and the BCD converter.
interface bin2bcd_seq_if
  import bin2bcd_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int NDIG = NDIG_DEF
);

  logic              inValid;
  logic              inReady;
  logic [IN_W-1:0]   inData;
  logic              outValid;
  logic [4*NDIG-1:0] outData;
  logic              ovf;

  modport master (
    output inValid, inData,
    input  inReady, outValid, outData, ovf
  );

  modport slave (
    input  inValid, inData,
    output inReady, outValid, outData, ovf
  );

endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added before the shift.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits in the result.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int NDIG = NDIG_DEF
) (
  input logic          clk_i,
  input logic          rst_i,
  bin2bcd_seq_if.slave bus
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int ACC_W = 4 * NDIG;

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    accAdj, accShown;
  logic [ACC_W-1:0]    out_q, out_d;
  logic [IN_W-1:0]     sreg_q, sreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovfPend_q, ovfPend_d;
  logic                ovf_q, ovf_d;
  logic                outValid_q, outValid_d;
  logic [ACC_W+IN_W-1:0] shifted;

  for (genvar g = 0; g < NDIG; g++) begin : gDigit
    bcd_add3 uAdd3 (
      .d_i (acc_q[4*g +: 4]),
      .d_o (accAdj[4*g +: 4])
    );
  end

  assign shifted = {accAdj, sreg_q} << 1;

`ifdef LEADING_ZERO_BLANK_EN
  // Scan from the top digit down; blanking stops at the first nonzero digit.
  always_comb begin
    logic lead;
    accShown = acc_q;
    lead     = 1'b1;
    for (int i = NDIG - 1; i > 0; i--) begin
      if (lead && (acc_q[4*i +: 4] == 4'h0)) begin
        accShown[4*i +: 4] = BLANK_NIBBLE;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign accShown = acc_q;
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    ovfPend_d  = ovfPend_q;
    out_d      = out_q;
    ovf_d      = ovf_q;
    outValid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.inValid) begin
          state_d   = SHIFT;
          sreg_d    = bus.inData;
          acc_d     = '0;
          cnt_d     = CNT_W'(IN_W);
          ovfPend_d = (32'(bus.inData) > 32'(MAX_VAL));
        end
      end
      SHIFT: begin
        acc_d  = shifted[ACC_W+IN_W-1:IN_W];
        sreg_d = shifted[IN_W-1:0];
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d    = IDLE;
        outValid_d = 1'b1;
        ovf_d      = ovfPend_q;
        out_d      = ovfPend_q ? {NDIG{BLANK_NIBBLE}} : accShown;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      sreg_q     <= '0;
      cnt_q      <= '0;
      ovfPend_q  <= 1'b0;
      out_q      <= '0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      ovfPend_q  <= ovfPend_d;
      out_q      <= out_d;
      ovf_q      <= ovf_d;
      outValid_q <= outValid_d;
    end
  end

  assign bus.inReady  = (state_q == IDLE);
  assign bus.outValid = outValid_q;
  assign bus.outData  = out_q;
  assign bus.ovf      = ovf_q;

endmodule
